// File: rtl/lsu_mem_master_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_mem_master_if
// Request, response and data-memory bus of the LSU memory master.
// The master modport is the LSU view; the slave modport is the
// environment view (execute stage, response consumer and memory).
// Revision: 1.0
// ----------------------------------------------------------------------------
interface lsu_mem_master_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [1:0]        req_size_i;
  logic              req_unsigned_i;
  logic [AWIDTH-1:0] req_addr_i;
  logic [DWIDTH-1:0] req_wdata_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [DWIDTH-1:0] resp_rdata_o;
  logic              resp_err_o;
  logic [AWIDTH-1:0] mem_addr_o;
  logic [DWIDTH-1:0] mem_data_o;
  logic              mem_read_en_o;
  logic              mem_write_en_o;
  logic [DWIDTH-1:0] mem_data_i;

  modport master (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output req_ready_o,
    output resp_valid_o, resp_rdata_o, resp_err_o,
    input  resp_ready_i,
    output mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o,
    input  mem_data_i
  );

  modport slave (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  req_ready_o,
    input  resp_valid_o, resp_rdata_o, resp_err_o,
    output resp_ready_i,
    input  mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o,
    output mem_data_i
  );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_mem_master
// Single-outstanding load/store unit memory initiator. Converts byte, half
// and word accesses into aligned 32-bit memory cycles (sub-word stores use
// read-modify-write) and returns extended load data or an error.
// Optional macro LSU_ALIGN_CHECK_EN: misaligned half/word accesses are
// reported as errors instead of being forced to natural alignment.
// Revision: 1.0
// ----------------------------------------------------------------------------
module lsu_mem_master #(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000,
  parameter int                MEM_BYTES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  lsu_mem_master_if.master bus
);
  localparam int             AW1       = AWIDTH + 1;
  localparam logic [AW1-1:0] LAST_ADDR = {1'b0, BASE_ADDR} + AW1'(MEM_BYTES) - AW1'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;
  state_t state, state_nxt;

  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [DWIDTH-1:0] old_q;
  logic [DWIDTH-1:0] rdata_q;
  logic              err_q;

  logic              idle_rdy;
  logic              accept;
  logic [AWIDTH-1:0] acc_addr;
  logic              misalign;
  logic [AW1-1:0]    span;
  logic [AW1-1:0]    acc_last;
  logic              acc_err;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [DWIDTH-1:0] load_ext;
  logic [DWIDTH-1:0] merged;

  assign idle_rdy = (state == IDLE) && rst;
  assign accept   = bus.req_valid_i && idle_rdy;

  // Accept-time address normalisation and error classification
  always_comb begin
    acc_addr = bus.req_addr_i;
    misalign = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    misalign = ((bus.req_size_i == 2'b01) && bus.req_addr_i[0]) ||
               ((bus.req_size_i == 2'b10) && (bus.req_addr_i[1:0] != 2'b00));
`else
    if (bus.req_size_i == 2'b01) begin
      acc_addr[0] = 1'b0;
    end else if (bus.req_size_i == 2'b10) begin
      acc_addr[1:0] = 2'b00;
    end
`endif
    case (bus.req_size_i)
      2'b01:   span = AW1'(1);
      2'b10:   span = AW1'(3);
      default: span = '0;
    endcase
    // One extra bit so an access running past the top of the address space is caught
    acc_last = {1'b0, acc_addr} + span;
    acc_err  = (bus.req_size_i == 2'b11) || misalign ||
               (acc_addr < BASE_ADDR) || (acc_last > LAST_ADDR);
  end

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    lane_byte = bus.mem_data_i[{addr_q[1:0], 3'b000} +: 8];
    lane_half = bus.mem_data_i[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_ext = uns_q ? {{(DWIDTH-8){1'b0}}, lane_byte}
                                : {{(DWIDTH-8){lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = uns_q ? {{(DWIDTH-16){1'b0}}, lane_half}
                                : {{(DWIDTH-16){lane_half[15]}}, lane_half};
      default: load_ext = bus.mem_data_i;
    endcase
    merged = old_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and bus outputs
  always_comb begin
    state_nxt          = state;
    bus.req_ready_o    = idle_rdy;
    bus.resp_valid_o   = (state == RESP);
    bus.resp_rdata_o   = rdata_q;
    bus.resp_err_o     = err_q;
    bus.mem_addr_o     = {addr_q[AWIDTH-1:2], 2'b00};
    bus.mem_read_en_o  = (state == RD);
    bus.mem_write_en_o = (state == WR);
    bus.mem_data_o     = (state == WR) ? merged : '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (acc_err)                          state_nxt = RESP;
          else if (!bus.req_we_i)               state_nxt = RD;
          else if (bus.req_size_i == 2'b10)     state_nxt = WR;
          else                                  state_nxt = RD;
        end
      end
      RD:      state_nxt = we_q ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    if (bus.resp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, old-word capture and response data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we_i;
        size_q  <= bus.req_size_i;
        uns_q   <= bus.req_unsigned_i;
        addr_q  <= acc_addr;
        wdata_q <= bus.req_wdata_i;
        err_q   <= acc_err;
        rdata_q <= '0;
      end
      if (state == RD) begin
        old_q <= bus.mem_data_i;
        if (!we_q) rdata_q <= load_ext;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lsu_mem_master
// Directed and randomized bench for lsu_mem_master with a byte-level
// reference model, a physical memory model and a per-cycle compare process.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_lsu_mem_master;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam int          MEMB = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_master_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  lsu_mem_master #(.AWIDTH(AW), .DWIDTH(DW), .BASE_ADDR(BASE), .MEM_BYTES(MEMB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      16:      return 8'h01;
      17:      return 8'h7F;
      18:      return 8'hFF;
      19:      return 8'h80;
      default: return 8'((i * 37 + 11) & 255);
    endcase
  endfunction

  // Physical memory seen by the DUT
  logic [7:0]  pmem [MEMB];
  logic [31:0] poff;
  initial begin
    for (int i = 0; i < MEMB; i++) pmem[i] = init_byte(i);
    forever begin
      @(negedge clk);
      if (rst && bus.mem_write_en_o && ((bus.mem_addr_o - BASE) <= 32'(MEMB - 4)))
        for (int k = 0; k < 4; k++) pmem[12'(bus.mem_addr_o - BASE) + 12'(k)] = bus.mem_data_o[8*k +: 8];
    end
  end

  always_comb begin
    poff           = bus.mem_addr_o - BASE;
    bus.mem_data_i = 32'hDEAD_BEEF;
    if (poff <= 32'(MEMB - 4))
      bus.mem_data_i = {pmem[poff[11:0] + 12'd3], pmem[poff[11:0] + 12'd2],
                        pmem[poff[11:0] + 12'd1], pmem[poff[11:0]]};
  end

  // Response-ready source: manual or random
  logic rr_mode   = 1'b0;
  logic ready_man = 1'b1;
  logic rand_bit  = 1'b1;
  assign bus.resp_ready_i = rr_mode ? rand_bit : ready_man;
  initial forever begin
    @(posedge clk); #1;
    rand_bit = ($urandom_range(0, 3) != 0);
  end

  // Reference model: expected outcome of one request, from byte-level rules
  typedef struct {
    int          acc;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    logic        we;
    int          off;
    int          n;
    logic [31:0] wdata;
    bit          seen;
  } exp_t;

  logic [7:0] rmem [MEMB];
  int         cyc = 0;
  exp_t       q[$];

  function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    longint      a;
    int          n;
    logic [31:0] v;
    a = longint'(addr);
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e.err = (sz == 2'd3);
`ifdef LSU_ALIGN_CHECK_EN
    if ((a % n) != 0) e.err = 1'b1;
`else
    a = a - (a % n);
`endif
    if (a < longint'(BASE) || a + n > longint'(BASE) + MEMB) e.err = 1'b1;
    e.acc = cyc; e.we = we; e.n = n; e.wdata = wd; e.seen = 1'b0; e.rdata = '0;
    e.off = int'(a - longint'(BASE));
    if (e.err) e.lat = 1;
    else if (!we) begin
      e.lat = 2;
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(rmem[e.off + i]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      e.rdata = v;
    end else e.lat = (n == 4) ? 2 : 3;
    return e;
  endfunction

  // Compare process: protocol invariants and model check every cycle
  initial begin
    exp_t        e;
    logic [31:0] w;
    int          wb;
    for (int i = 0; i < MEMB; i++) rmem[i] = init_byte(i);
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        q.delete();
        chk("rst_rd_en", bus.mem_read_en_o, 0);
        chk("rst_wr_en", bus.mem_write_en_o, 0);
        chk("rst_resp_valid", bus.resp_valid_o, 0);
        chk("rst_req_ready", bus.req_ready_o, 0);
      end else begin
        chk("en_both", bus.mem_read_en_o & bus.mem_write_en_o, 0);
        chk("ready_and_valid", bus.req_ready_o & bus.resp_valid_o, 0);
        if (bus.req_ready_o || bus.resp_valid_o)
          chk("en_outside_access", bus.mem_read_en_o | bus.mem_write_en_o, 0);
        if (bus.mem_read_en_o || bus.mem_write_en_o) begin
          chk("access_pending", q.size(), 1);
          if (q.size() != 0) begin
            e  = q[0];
            wb = e.off & ~3;
            chk("err_no_access", e.err, 0);
            chk("mem_addr", bus.mem_addr_o, BASE + 32'(wb));
            if (bus.mem_write_en_o && !e.err) begin
              for (int k = 0; k < 4; k++) w[8*k +: 8] = rmem[wb + k];
              for (int k = 0; k < e.n; k++) w[8*((e.off & 3) + k) +: 8] = e.wdata[8*k +: 8];
              chk("mem_wdata", bus.mem_data_o, w);
            end
          end
        end
        if (bus.resp_valid_o) begin
          chk("resp_expected", q.size(), 1);
          if (q.size() != 0) begin
            e = q[0];
            chk("resp_err", bus.resp_err_o, e.err);
            chk("resp_rdata", bus.resp_rdata_o, e.rdata);
            if (!e.seen) begin
              e.seen = 1'b1;
              chk("latency", 32'(cyc - e.acc), 32'(e.lat));
              if (e.we && !e.err)
                for (int k = 0; k < e.n; k++) rmem[e.off + k] = e.wdata[8*k +: 8];
              q[0] = e;
            end
            if (bus.resp_ready_i) void'(q.pop_front());
          end
        end
        if (bus.req_valid_i && bus.req_ready_o)
          q.push_back(model(bus.req_we_i, bus.req_size_i, bus.req_unsigned_i,
                            bus.req_addr_i, bus.req_wdata_i));
      end
    end
  end

  task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd);
    bit ok;
    ok = 1'b0;
    bus.req_we_i = we; bus.req_size_i = sz; bus.req_unsigned_i = uns;
    bus.req_addr_i = addr; bus.req_wdata_i = wd; bus.req_valid_i = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready_o) ok = 1'b1;
    end
    chk("accept", ok, 1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
  endtask

  // Directed request with literal expectations on response and memory cycles
  task automatic dreq(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat,
                      input int exp_rd, input int exp_wr, input logic [31:0] exp_word);
    int          lat, nrd, nwr;
    logic [31:0] ww;
    bit          got;
    send(we, sz, uns, addr, wd);
    lat = 0; nrd = 0; nwr = 0; ww = '0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (bus.mem_read_en_o) nrd++;
      if (bus.mem_write_en_o) begin nwr++; ww = bus.mem_data_o; end
      if (bus.resp_valid_o) got = 1'b1;
    end
    chk({nm, "_resp"}, got, 1);
    chk({nm, "_err"}, bus.resp_err_o, exp_err);
    chk({nm, "_rdata"}, bus.resp_rdata_o, exp_rdata);
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_rd_cycles"}, nrd, exp_rd);
    chk({nm, "_wr_cycles"}, nwr, exp_wr);
    if (exp_wr != 0) chk({nm, "_wword"}, ww, exp_word);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] v0;
    bit          got;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'b00;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_addr", bus.mem_addr_o, BASE);
    chk("reset_mem_data", bus.mem_data_o, 0);
    chk("reset_rdata", bus.resp_rdata_o, 0);
    chk("reset_err", bus.resp_err_o, 0);
    chk("reset_valid", bus.resp_valid_o, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", bus.req_ready_o, 1);

    dreq("lb_s",  0, 2'd0, 0, 32'h0100_0012, 0, 0, 32'hFFFF_FFFF, 2, 1, 0, 0);
    dreq("lb_u",  0, 2'd0, 1, 32'h0100_0013, 0, 0, 32'h0000_0080, 2, 1, 0, 0);
    dreq("lh_s",  0, 2'd1, 0, 32'h0100_0012, 0, 0, 32'hFFFF_80FF, 2, 1, 0, 0);
    dreq("lw",    0, 2'd2, 0, 32'h0100_0010, 0, 0, 32'h80FF_7F01, 2, 1, 0, 0);
`ifdef LSU_ALIGN_CHECK_EN
    dreq("lh_mis", 0, 2'd1, 0, 32'h0100_0011, 0, 1, 32'h0, 1, 0, 0, 0);
`else
    dreq("lh_mis", 0, 2'd1, 0, 32'h0100_0011, 0, 0, 32'h0000_7F01, 2, 1, 0, 0);
`endif
    dreq("sb",    1, 2'd0, 0, 32'h0100_0011, 32'h0000_00AA, 0, 0, 3, 1, 1, 32'h80FF_AA01);
    dreq("lw_sb", 0, 2'd2, 0, 32'h0100_0010, 0, 0, 32'h80FF_AA01, 2, 1, 0, 0);
    dreq("lw_low_oor", 0, 2'd2, 0, 32'h00FF_FFFC, 0, 1, 0, 1, 0, 0, 0);
    dreq("sb_high_oor", 1, 2'd0, 0, 32'h0100_1000, 32'h55, 1, 0, 1, 0, 0, 0);
`ifdef LSU_ALIGN_CHECK_EN
    dreq("sw_top", 1, 2'd2, 0, 32'h0100_0FFE, 32'h1234_5678, 1, 0, 1, 0, 0, 0);
`else
    dreq("sw_top", 1, 2'd2, 0, 32'h0100_0FFE, 32'h1234_5678, 0, 0, 2, 0, 1, 32'h1234_5678);
`endif

    // Back-pressure: response must hold while resp_ready is low
    ready_man = 1'b0;
    send(0, 2'd2, 0, 32'h0100_0010, 0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.resp_valid_o) got = 1'b1;
    end
    chk("bp_resp", got, 1);
    v0 = bus.resp_rdata_o;
    chk("bp_rdata", v0, 32'h80FF_AA01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", bus.resp_valid_o, 1);
      chk("bp_rdata_hold", bus.resp_rdata_o, v0);
      chk("bp_ready_low", bus.req_ready_o, 0);
    end
    @(posedge clk); #1;
    ready_man = 1'b1;
    @(negedge clk);
    chk("bp_valid_before_edge", bus.resp_valid_o, 1);
    @(posedge clk); #1;
    chk("bp_idle_valid", bus.resp_valid_o, 0);
    chk("bp_idle_ready", bus.req_ready_o, 1);

    // Reset during the read phase of a sub-word store
    send(1, 2'd0, 0, 32'h0100_0021, 32'h55);
    chk("rst_mid_rd_phase", bus.mem_read_en_o, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_rd_en", bus.mem_read_en_o, 0);
    chk("rst_mid_wr_en", bus.mem_write_en_o, 0);
    chk("rst_mid_valid", bus.resp_valid_o, 0);
    @(negedge clk);
    @(posedge clk); #1;
    chk("rst_mid_no_wr", bus.mem_write_en_o, 0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_idle", bus.req_ready_o, 1);
    dreq("lw_after_rst", 0, 2'd2, 0, 32'h0100_0020, 0, 0,
         {init_byte(35), init_byte(34), init_byte(33), init_byte(32)}, 2, 1, 0, 0);

    // Randomized traffic with random response back-pressure
    rr_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      send(1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
           1'($urandom_range(0, 1)),
           BASE - 32'd8 + 32'($urandom_range(0, MEMB + 15)),
           $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rr_mode = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready_o) got = 1'b1;
    end
    chk("drain", got, 1);
    @(negedge clk);
    chk("queue_empty", q.size(), 0);
    v0 = '0;
    for (int i = 0; i < MEMB; i++) if (pmem[i] !== rmem[i]) v0++;
    chk("mem_image_mismatches", v0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
